// File: rtl/vsync_pack.sv
// Packs PACK camera pixels per AXI4-Stream beat (tuser = frame start, tlast = line end); beats reach the FIFO one cycle after commit.
// Downstream tready stalls a FWFT FIFO; when it runs down to its last free entry the line is cut with tlast and the rest of the frame is dropped.
module vsync_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         pix_valid,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         framevalid,
    input  logic                         linevalid,
    output logic [DATA_WIDTH*PACK-1:0]   m_axis_data_tdata,
    output logic [PACK-1:0]              m_axis_data_tkeep,
    output logic                         m_axis_data_tlast,
    output logic                         m_axis_data_tuser,
    output logic                         m_axis_data_tvalid,
    input  logic                         m_axis_data_tready,
    output logic                         overflow,
    output logic [15:0]                  drop_count,
    output logic [15:0]                  line_length
);
    localparam int BW = DATA_WIDTH * PACK;
    localparam int LW = $clog2(PACK + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP} state_t;

    typedef struct packed {
        logic            tuser;
        logic            tlast;
        logic [PACK-1:0] tkeep;
        logic [BW-1:0]   tdata;
    } beat_t;

    state_t          state_q, state_d;
    logic            fv_q, lv_q;
    logic [BW-1:0]   pack_q, pack_d;
    logic [LW-1:0]   lanes_q, lanes_d;
    logic            first_q, first_d;
    logic            stg_vld_q, stg_vld_d;
    beat_t           stg_q, stg_d;
    logic [LW-1:0]   stg_lanes_q, stg_lanes_d;

    beat_t           mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, occ;
    logic            overflow_q;
    logic [15:0]     drop_q, len_q, line_cnt_q;

    logic            fv_rise, fv_fall, lv_fall, accept, line_end;
    logic            pop, wr_do, forced;
    beat_t           wr_entry, head;
    logic [16:0]     cnt_sum;
    logic [15:0]     cnt_sat;

    function automatic logic [PACK-1:0] keep_of(input logic [LW-1:0] n);
        logic [PACK-1:0] k;
        k = '0;
        for (int i = 0; i < PACK; i++) k[i] = (LW'(i) < n);
        return k;
    endfunction

    assign fv_rise  = framevalid & ~fv_q;
    assign fv_fall  = ~framevalid & fv_q;
    assign lv_fall  = ~linevalid & lv_q;
    assign accept   = (state_q == CAPTURE) & pix_valid & framevalid & linevalid;
    assign line_end = (state_q == CAPTURE) & (lv_fall | (fv_fall & lv_q));

    // One entry is held back so a truncating tlast always has somewhere to land.
    assign m_axis_data_tvalid = (count_q != '0);
    assign pop    = m_axis_data_tvalid & m_axis_data_tready;
    assign occ    = count_q - CW'(pop);
    assign wr_do  = stg_vld_q && (occ <= CW'(FIFO_DEPTH - 2));
    assign forced = stg_vld_q && (occ == CW'(FIFO_DEPTH - 2));

    always_comb begin
        wr_entry       = stg_q;
        wr_entry.tlast = stg_q.tlast | forced;
    end

    assign cnt_sum = {1'b0, line_cnt_q} + 17'(stg_lanes_q);
    assign cnt_sat = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        lanes_d     = lanes_q;
        first_d     = first_q;
        stg_vld_d   = 1'b0;
        stg_d       = stg_q;
        stg_lanes_d = stg_lanes_q;

        unique case (state_q)
            IDLE: begin
                if (fv_rise && enable) begin
                    state_d = CAPTURE;
                    first_d = 1'b1;
                end
            end
            CAPTURE: if (fv_fall) state_d = IDLE;
            DROP:    if (fv_fall) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A full register is only committed once the next pixel proves the line continues.
        if (accept) begin
            if (lanes_q == LW'(PACK)) begin
                stg_vld_d   = 1'b1;
                stg_d.tuser = first_q;
                stg_d.tlast = 1'b0;
                stg_d.tkeep = {PACK{1'b1}};
                stg_d.tdata = pack_q;
                stg_lanes_d = lanes_q;
                first_d     = 1'b0;
                pack_d      = '0;
                pack_d[DATA_WIDTH-1:0] = data;
                lanes_d     = LW'(1);
            end else begin
                for (int i = 0; i < PACK; i++)
                    if (lanes_q == LW'(i)) pack_d[i*DATA_WIDTH +: DATA_WIDTH] = data;
                lanes_d = lanes_q + LW'(1);
            end
        end

        if (line_end && (lanes_q != '0)) begin
            stg_vld_d   = 1'b1;
            stg_d.tuser = first_q;
            stg_d.tlast = 1'b1;
            stg_d.tkeep = keep_of(lanes_q);
            stg_d.tdata = pack_q;
            stg_lanes_d = lanes_q;
            first_d     = 1'b0;
            pack_d      = '0;
            lanes_d     = '0;
        end

        if (forced && (state_q == CAPTURE)) begin
            stg_vld_d = 1'b0;
            pack_d    = '0;
            lanes_d   = '0;
            if (!fv_fall) state_d = DROP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            fv_q        <= 1'b1;
            lv_q        <= 1'b1;
            pack_q      <= '0;
            lanes_q     <= '0;
            first_q     <= 1'b0;
            stg_vld_q   <= 1'b0;
            stg_q       <= '0;
            stg_lanes_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            len_q       <= '0;
            line_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fv_q        <= framevalid;
            lv_q        <= linevalid;
            pack_q      <= pack_d;
            lanes_q     <= lanes_d;
            first_q     <= first_d;
            stg_vld_q   <= stg_vld_d;
            stg_q       <= stg_d;
            stg_lanes_q <= stg_lanes_d;
            if (wr_do) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= occ + CW'(wr_do);
            overflow_q  <= forced;
            if (forced) drop_q <= drop_q + 16'd1;
            if (wr_do) begin
                if (wr_entry.tlast) begin
                    len_q      <= cnt_sat;
                    line_cnt_q <= '0;
                end else begin
                    line_cnt_q <= cnt_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_do && !reset) mem[wr_ptr_q] <= wr_entry;
    end

    assign head               = m_axis_data_tvalid ? mem[rd_ptr_q] : '0;
    assign m_axis_data_tdata  = head.tdata;
    assign m_axis_data_tkeep  = head.tkeep;
    assign m_axis_data_tlast  = head.tlast;
    assign m_axis_data_tuser  = head.tuser;
    assign overflow           = overflow_q;
    assign drop_count         = drop_q;
    assign line_length        = len_q;

endmodule

// File: tb/tb_vsync_pack.sv
`timescale 1ns/1ps
// Bench for vsync_pack: directed frames queue their expected beats at issue time;
// a negedge monitor pops and compares every accepted beat and checks payload stability while stalled.
module tb_vsync_pack;
    localparam int DW    = 8;
    localparam int PK    = 4;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic          tuser;
        logic          tlast;
        logic [PK-1:0] tkeep;
        logic [DW*PK-1:0] tdata;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic pix_valid = 1'b0;
    logic framevalid = 1'b0;
    logic linevalid = 1'b0;
    logic [DW-1:0] data = '0;
    logic tready = 1'b1;
    logic ready_cfg = 1'b1;
    logic rand_rdy = 1'b0;

    logic [DW*PK-1:0] tdata;
    logic [PK-1:0]    tkeep;
    logic             tlast, tuser, tvalid, overflow;
    logic [15:0]      drop_count, line_length;

    beat_t exp_q[$];
    beat_t held;
    logic  stalled = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    ovf_seen = 0;

    vsync_pack #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid), .data(data),
        .framevalid(framevalid), .linevalid(linevalid),
        .m_axis_data_tdata(tdata), .m_axis_data_tkeep(tkeep), .m_axis_data_tlast(tlast),
        .m_axis_data_tuser(tuser), .m_axis_data_tvalid(tvalid), .m_axis_data_tready(tready),
        .overflow(overflow), .drop_count(drop_count), .line_length(line_length)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        tready = rand_rdy ? 1'($urandom_range(0, 1)) : ready_cfg;
    end

    always @(negedge clk) begin : monitor
        beat_t cur, e;
        cur = '{tuser: tuser, tlast: tlast, tkeep: tkeep, tdata: tdata};
        if (overflow) ovf_seen++;
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!tvalid || cur !== held) begin
                    errors++;
                    $display("FAIL stall_stable: got vld=%0d beat=%h, required vld=1 beat=%h", tvalid, cur, held);
                end
            end
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h, required no beat", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat: got user=%0d last=%0d keep=%h data=%h, required user=%0d last=%0d keep=%h data=%h",
                                 cur.tuser, cur.tlast, cur.tkeep, cur.tdata, e.tuser, e.tlast, e.tkeep, e.tdata);
                    end
                end
            end
            stalled = tvalid && !tready;
            held    = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic exp_beat(input logic u, input logic l, input logic [PK-1:0] k, input logic [31:0] d);
        beat_t x;
        x = '{tuser: u, tlast: l, tkeep: k, tdata: d};
        exp_q.push_back(x);
    endtask

    // Expected beats for an n-pixel line whose pixel values count up from base.
    task automatic exp_line(input int n, input int base, input logic first);
        beat_t x;
        int    cnt;
        for (int b = 0; b * PK < n; b++) begin
            cnt = (n - b * PK < PK) ? n - b * PK : PK;
            x = '0;
            for (int j = 0; j < cnt; j++) x.tdata[j*DW +: DW] = DW'(base + b * PK + j);
            x.tkeep = PK'((1 << cnt) - 1);
            x.tlast = (b * PK + cnt == n);
            x.tuser = first && (b == 0);
            exp_q.push_back(x);
        end
    endtask

    task automatic fv_up();
        framevalid = 1'b1;
        repeat (3) tick();
    endtask

    task automatic fv_down();
        linevalid = 1'b0;
        pix_valid = 1'b0;
        repeat (2) tick();
        framevalid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_line(input int n, input int base, input int gap);
        for (int i = 0; i < n; i++) begin
            linevalid = 1'b1;
            pix_valid = 1'b1;
            data      = DW'(base + i);
            tick();
        end
        linevalid = 1'b0;
        pix_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (8) tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int ovf0;

        // Reset released mid-frame: that frame must be skipped.
        framevalid = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_drop_count", 32'(drop_count), 32'd0);
        chk("rst_line_length", 32'(line_length), 32'd0);
        tick();
        send_line(8, 'hE0, 6);
        fv_down();
        repeat (10) tick();
        chk("midframe_no_output", 32'(tvalid), 32'd0);

        // Basic frame: 2 lines x 8 pixels.
        exp_beat(1'b1, 1'b0, 4'hF, 32'h03020100);
        exp_beat(1'b0, 1'b1, 4'hF, 32'h07060504);
        exp_beat(1'b0, 1'b0, 4'hF, 32'h0B0A0908);
        exp_beat(1'b0, 1'b1, 4'hF, 32'h0F0E0D0C);
        fv_up();
        send_line(8, 'h00, 6);
        send_line(8, 'h08, 6);
        fv_down();
        wait_drain("basic_drain", 100);
        chk("basic_line_length", 32'(line_length), 32'd8);

        // Partial beats on 6-pixel lines, then an exact 4-pixel line.
        exp_beat(1'b1, 1'b0, 4'hF, 32'h23222120);
        exp_beat(1'b0, 1'b1, 4'h3, 32'h00002524);
        exp_beat(1'b0, 1'b0, 4'hF, 32'h29282726);
        exp_beat(1'b0, 1'b1, 4'h3, 32'h00002B2A);
        exp_beat(1'b0, 1'b1, 4'hF, 32'h2F2E2D2C);
        fv_up();
        send_line(6, 'h20, 6);
        chk("partial_line_length", 32'(line_length), 32'd6);
        send_line(6, 'h26, 6);
        send_line(4, 'h2C, 6);
        fv_down();
        wait_drain("partial_drain", 100);
        chk("exact_line_length", 32'(line_length), 32'd4);

        // Enable low at frame start: ignored.
        enable = 1'b0;
        fv_up();
        send_line(8, 'h90, 6);
        fv_down();
        repeat (10) tick();
        chk("disabled_no_output", 32'(tvalid), 32'd0);

        // Enable dropped mid-frame: frame still captured.
        enable = 1'b1;
        exp_beat(1'b1, 1'b1, 4'hF, 32'h53525150);
        fv_up();
        enable = 1'b0;
        send_line(4, 'h50, 6);
        fv_down();
        wait_drain("enable_drop_drain", 100);

        // Enable raised mid-frame: frame still ignored.
        fv_up();
        enable = 1'b1;
        send_line(4, 'h58, 6);
        fv_down();
        repeat (10) tick();
        chk("enable_late_no_output", 32'(tvalid), 32'd0);

        // Random backpressure over 3 lines of 13 pixels.
        rand_rdy = 1'b1;
        exp_line(13, 'h60, 1'b1);
        exp_line(13, 'h6D, 1'b0);
        exp_line(13, 'h7A, 1'b0);
        fv_up();
        send_line(13, 'h60, 40);
        send_line(13, 'h6D, 40);
        send_line(13, 'h7A, 40);
        fv_down();
        wait_drain("backpressure_drain", 400);
        rand_rdy  = 1'b0;
        ready_cfg = 1'b1;
        repeat (3) tick();
        chk("bp_line_length", 32'(line_length), 32'd13);

        // Overflow: 7 beats fit, the 7th closes the line, rest of the frame is dropped.
        ready_cfg = 1'b0;
        repeat (3) tick();
        exp_line(28, 'h80, 1'b1);
        ovf0 = ovf_seen;
        fv_up();
        send_line(64, 'h80, 6);
        send_line(8, 'hC0, 6);
        fv_down();
        chk("ovf_pulses", 32'(ovf_seen - ovf0), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        chk("ovf_tvalid_held", 32'(tvalid), 32'd1);
        ready_cfg = 1'b1;
        wait_drain("ovf_drain", 100);
        chk("ovf_empty_after", 32'(tvalid), 32'd0);
        exp_line(8, 'h10, 1'b1);
        fv_up();
        send_line(8, 'h10, 6);
        fv_down();
        wait_drain("post_ovf_drain", 100);

        // Reset for one cycle mid-line.
        ready_cfg = 1'b0;
        repeat (3) tick();
        fv_up();
        for (int i = 0; i < 5; i++) begin
            linevalid = 1'b1;
            pix_valid = 1'b1;
            data      = DW'('hA0 + i);
            tick();
        end
        data  = 8'hA5;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", 32'(tvalid), 32'd0);
        chk("midrst_drop_count", 32'(drop_count), 32'd0);
        chk("midrst_line_length", 32'(line_length), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            data = DW'('hA6 + i);
            tick();
        end
        fv_down();
        ready_cfg = 1'b1;
        repeat (20) tick();
        chk("midrst_no_output", 32'(tvalid), 32'd0);
        exp_beat(1'b1, 1'b1, 4'hF, 32'h73727170);
        fv_up();
        send_line(4, 'h70, 6);
        fv_down();
        wait_drain("fresh_frame_drain", 100);
        chk("fresh_line_length", 32'(line_length), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
